muldiv_unit: RTL

- Iterative RV64M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Receives the same forwarded operands a, b; decode routes M-extension ops here instead of to the ALU.
- Stalls the pipeline via a valid/ready handshake while iterating; its result is muxed with the ALU output into the execute→memory register.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV64M multiply/divide unit for the execute stage.
//            Multiplies by 64-step shift-add and divides by 64-step
//            restoring division on operand magnitudes, then applies sign
//            and W-op fixups. Divide-by-zero and reserved ops bypass the
//            iteration loop.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            flush      - abort any operation, return to IDLE
//            in_valid   - op/a/b valid       in_ready  - unit can accept
//            op         - 0 MUL 1 MULW 2 DIV 3 DIVU 4 REM 5 REMU
//                         6 DIVW 7 DIVUW 8 REMW 9 REMUW, 10-15 reserved
//            a, b       - operands rs1, rs2
//            out_valid  - c valid            out_ready - consumer takes c
//            c          - result
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              setup_q;     // first BUSY cycle: fast-path decision
  logic              is_mul_q, is_rsv_q, is_rem_q, is_w_q;
  logic              neg_q_q, neg_r_q;
  logic [XLEN-1:0]   dvsr_q;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;       // {product hi / remainder, multiplier / quotient}
  logic [XLEN-1:0]   c_q;
  logic              out_valid_q;

  // Sign-extend the low word for W ops.
  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    wfix = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // ---------------- accept-time decode and operand preparation ----------------
  logic            is_mul_d, is_rsv_d, is_rem_d, is_w_d, sdiv_d, wsx_d, wzx_d;
  logic [XLEN-1:0] a_ext_d, b_ext_d, a_mag_d, b_mag_d;

  always_comb begin
    is_rsv_d = (op >= 4'd10);
    is_mul_d = (op <= 4'd1);
    is_rem_d = (op == 4'd4) || (op == 4'd5) || (op == 4'd8) || (op == 4'd9);
    is_w_d   = (op == 4'd1) || ((op >= 4'd6) && !is_rsv_d);
    sdiv_d   = (op == 4'd2) || (op == 4'd4) || (op == 4'd6) || (op == 4'd8);
    wsx_d    = (op == 4'd1) || (op == 4'd6) || (op == 4'd8);
    wzx_d    = (op == 4'd7) || (op == 4'd9);
    a_ext_d  = a;
    b_ext_d  = b;
    if (wsx_d) begin
      a_ext_d = {{(XLEN-32){a[31]}}, a[31:0]};
      b_ext_d = {{(XLEN-32){b[31]}}, b[31:0]};
    end else if (wzx_d) begin
      a_ext_d = {{(XLEN-32){1'b0}}, a[31:0]};
      b_ext_d = {{(XLEN-32){1'b0}}, b[31:0]};
    end
    // Most-negative value maps to itself, which is its correct unsigned magnitude.
    a_mag_d = (sdiv_d && a_ext_d[XLEN-1]) ? -a_ext_d : a_ext_d;
    b_mag_d = (sdiv_d && b_ext_d[XLEN-1]) ? -b_ext_d : b_ext_d;
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum_d;
  logic [XLEN:0]     div_shift_d;
  logic [XLEN-1:0]   div_sub_d;
  logic              div_ge_d;
  logic [2*XLEN-1:0] acc_d;

  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    div_shift_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge_d    = (div_shift_d >= {1'b0, dvsr_q});
    // When the trial subtraction succeeds the difference is below the divisor,
    // so truncating to XLEN bits loses nothing.
    div_sub_d   = div_shift_d[XLEN-1:0] - dvsr_q;
    if (is_mul_q)
      acc_d = {mul_sum_d, acc_q[XLEN-1:1]};
    else if (div_ge_d)
      acc_d = {div_sub_d, acc_q[XLEN-2:0], 1'b1};
    else
      acc_d = {div_shift_d[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // ---------------- result formation ----------------
  logic [XLEN-1:0] quo_d, rem_d, res_d, fast_d;
  logic            dvz_d;

  always_comb begin
    quo_d  = neg_q_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem_d  = neg_r_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    res_d  = wfix(is_mul_q ? acc_d[XLEN-1:0] : (is_rem_q ? rem_d : quo_d), is_w_q);
    dvz_d  = !is_mul_q && !is_rsv_q && (dvsr_q == '0);
    // Divide by zero: remainder is the dividend, rebuilt from its magnitude
    // and recorded sign; quotient is all ones.
    fast_d = is_rsv_q ? '0 :
             wfix(is_rem_q ? (neg_r_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]) : '1, is_w_q);
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      setup_q     <= 1'b0;
      is_mul_q    <= 1'b0;
      is_rsv_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      is_w_q      <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dvsr_q      <= '0;
      acc_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      setup_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= BUSY;
            setup_q  <= 1'b1;
            cnt_q    <= '0;
            is_mul_q <= is_mul_d;
            is_rsv_q <= is_rsv_d;
            is_rem_q <= is_rem_d;
            is_w_q   <= is_w_d;
            neg_q_q  <= sdiv_d && (a_ext_d[XLEN-1] ^ b_ext_d[XLEN-1]);
            neg_r_q  <= sdiv_d && a_ext_d[XLEN-1];
            dvsr_q   <= b_mag_d;
            acc_q    <= {{XLEN{1'b0}}, a_mag_d};
          end
        end
        BUSY: begin
          if (setup_q) begin
            setup_q <= 1'b0;
            if (is_rsv_q || dvz_d) begin
              c_q         <= fast_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              c_q         <= res_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign c         = c_q;

endmodule
`default_nettype wire
